// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the ADD-unit arbiter: state encoding, default
// datapath width and the signed-overflow rule used on the sum.
package add_arbiter_pkg;

    // Default operand width, shared with the ADD unit.
    localparam int DATA_WIDTH = 32;

    // IDLE: result register empty.  HOLD: result register full.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Signed overflow: both operands share a sign that the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bundle between the requesters plus result consumer
// (master) and the arbiter (slave).
interface add_arbiter_if
    import add_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DATA_WIDTH,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_sum;
    logic                     resp_ovf;
    logic [CNT_W-1:0]         ops_done;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_ovf, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_ovf, ops_done
    );
endinterface

// File: rtl/add_arbiter_add.sv
// The datapath ADD unit: plain modulo-2^WIDTH addition, carry-out dropped.
module add_unit
    import add_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/add_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning upward from rr_ptr with
// wrap-around.  Produces both the one-hot grant and its index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   pos;

    // Rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_any = 1'b0;
        grant_idx = '0;
        pos       = 0;
        dbl       = {req_valid, req_valid};
        rot       = NUM_REQ'(dbl >> rr_ptr);
        // Descending scan: the last hit written is the lowest offset.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = int'(rr_ptr) + i;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                grant_any = 1'b1;
                grant_idx = ID_W'(pos);
            end
        end
    end

    // Decode the picked index back to a one-hot vector.
    always_comb begin
        grant_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_oh[j] = grant_any && (grant_idx == ID_W'(j));
        end
    end
endmodule

// File: rtl/add_arbiter.sv
// Shares one ADD unit between NUM_REQ requesters.  One result register;
// a new operation is accepted whenever that register is empty or is being
// drained in the same cycle, so back-to-back issue has no bubble.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DATA_WIDTH,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    add_arbiter_if.slave bus
);
    arb_state_e         state, state_next;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_next;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept;
    logic               grant;
    logic [WIDTH-1:0]   op_a, op_b, sum;
    logic               ovf;

    logic [WIDTH-1:0]   resp_sum_q;
    logic [ID_W-1:0]    resp_id_q;
    logic               resp_ovf_q;
    logic [CNT_W-1:0]   ops_done_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .rr_ptr    (rr_ptr),
        .req_valid (bus.req_valid),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The result register can take a new value when empty or being drained.
    assign accept = (state == IDLE) || ((state == HOLD) && bus.resp_ready);
    assign grant  = accept && grant_any;

    // Grant depends only on valids, pointer and consumer state, never on data.
    assign bus.req_ready = grant ? grant_oh : '0;

    // Steer the granted requester's operands into the single ADD unit.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                op_a = bus.req_a[i*WIDTH +: WIDTH];
                op_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    add_unit #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    assign ovf = add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);

    // Next state: fill on grant, drain to IDLE only when nothing replaces it.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (grant) state_next = HOLD;
            HOLD: if (bus.resp_ready) state_next = grant ? HOLD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointer moves to the slot after the winner on every grant.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant) begin
            rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // Result register: captures sum, overflow and owner on each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_sum_q <= '0;
            resp_id_q  <= '0;
            resp_ovf_q <= 1'b0;
        end else if (grant) begin
            resp_sum_q <= sum;
            resp_id_q  <= grant_idx;
            resp_ovf_q <= ovf;
        end
    end

    // Completed-response counter, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_done_q <= '0;
        end else if ((state == HOLD) && bus.resp_ready && (ops_done_q != '1)) begin
            ops_done_q <= ops_done_q + CNT_W'(1);
        end
    end

    assign bus.resp_valid = (state == HOLD);
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_ovf   = resp_ovf_q;
    assign bus.ops_done   = ops_done_q;
endmodule

// File: tb/tb_add_arbiter.sv
// Directed testbench for add_arbiter: a 4-requester instance with a 16-bit
// counter, plus a second instance with a 4-bit counter for saturation.
module tb_add_arbiter;
    logic clk;
    logic reset;
    logic sat_reset;
    int   errors;
    int   checks;

    add_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .ID_W(2), .CNT_W(16)) bus ();
    add_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .ID_W(2), .CNT_W(4))  sbus ();

    add_arbiter #(.NUM_REQ(4), .WIDTH(32), .ID_W(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    add_arbiter #(.NUM_REQ(4), .WIDTH(32), .ID_W(2), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (sat_reset),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.resp_id); end
        checks++; if (bus.resp_sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %h want 0", bus.resp_sum); end
        checks++; if (bus.resp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.resp_ovf); end
        checks++; if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops: got %0d want 0", bus.ops_done); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    endtask

    task automatic test_single();
        bus.req_valid  = 4'b0001;
        set_op(0, 32'd15, 32'd15);
        bus.resp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", bus.resp_id); end
        checks++; if (bus.resp_sum !== 32'd30) begin errors++; $display("FAIL single_sum: got %0d want 30", bus.resp_sum); end
        checks++; if (bus.resp_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", bus.resp_ovf); end
        checks++; if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL single_ops_pre: got %0d want 0", bus.ops_done); end
        step();
        checks++; if (bus.ops_done !== 16'd1) begin errors++; $display("FAIL single_ops: got %0d want 1", bus.ops_done); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i), 32'(i));
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            #1;
            checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, 4'(1 << g)); end
            step();
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(g) || bus.resp_sum !== 32'(2 * g)) begin
                errors++;
                $display("FAIL rr_result[%0d]: got valid=%b id=%0d sum=%0d want valid=1 id=%0d sum=%0d",
                         k, bus.resp_valid, bus.resp_id, bus.resp_sum, g, 2 * g);
            end
        end
        bus.req_valid = 4'b0000;
        step();
        checks++; if (bus.ops_done !== 16'd5) begin errors++; $display("FAIL rr_ops: got %0d want 5", bus.ops_done); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_valid  = 4'b0001;
        set_op(0, 32'd100, 32'd23);
        bus.resp_ready = 1'b0;
        step();
        bus.req_valid = 4'b0100;
        set_op(2, 32'd5, 32'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.req_ready); end
            step();
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_sum !== 32'd123) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d sum=%0d want valid=1 id=0 sum=123",
                         k, bus.resp_valid, bus.resp_id, bus.resp_sum);
            end
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release: got %b want 0100", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        checks++; if (bus.resp_id !== 2'd2 || bus.resp_sum !== 32'd11) begin errors++; $display("FAIL bp_next: got id=%0d sum=%0d want id=2 sum=11", bus.resp_id, bus.resp_sum); end
        checks++; if (bus.ops_done !== 16'd1) begin errors++; $display("FAIL bp_ops: got %0d want 1", bus.ops_done); end
        step();
        checks++; if (bus.ops_done !== 16'd2) begin errors++; $display("FAIL bp_ops_end: got %0d want 2", bus.ops_done); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b0010;
        set_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        checks++; if (bus.resp_sum !== 32'h8000_0000 || bus.resp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos: got sum=%h ovf=%b want 80000000 1", bus.resp_sum, bus.resp_ovf); end
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        checks++; if (bus.resp_sum !== 32'h0000_0000 || bus.resp_ovf !== 1'b0 || bus.resp_id !== 2'd1) begin errors++; $display("FAIL ovf_wrap: got sum=%h ovf=%b id=%0d want 00000000 0 1", bus.resp_sum, bus.resp_ovf, bus.resp_id); end
        set_op(1, 32'h8000_0000, 32'h8000_0000);
        step();
        checks++; if (bus.resp_sum !== 32'h0000_0000 || bus.resp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg: got sum=%h ovf=%b want 00000000 1", bus.resp_sum, bus.resp_ovf); end
        bus.req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_hold();
        do_reset();
        bus.req_valid  = 4'b0010;
        set_op(1, 32'd9, 32'd9);
        bus.resp_ready = 1'b0;
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL rh_pre: got %b want 1", bus.resp_valid); end
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;
        reset          = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL rh_ops: got %0d want 0", bus.ops_done); end
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rh_ptr: got %b want 0001", bus.req_ready); end
        bus.req_valid = 4'b1000;
        set_op(3, 32'd40, 32'd2);
        step();
        bus.req_valid = 4'b0000;
        checks++; if (bus.resp_id !== 2'd3 || bus.resp_sum !== 32'd42) begin errors++; $display("FAIL rh_next: got id=%0d sum=%0d want id=3 sum=42", bus.resp_id, bus.resp_sum); end
        step();
    endtask

    task automatic test_saturation();
        sbus.req_valid  = 4'b1111;
        sbus.req_a      = '0;
        sbus.req_b      = '0;
        sbus.resp_ready = 1'b1;
        sat_reset       = 1'b1;
        step();
        sat_reset = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            int exp_cnt;
            step();
            exp_cnt = (k - 1 > 15) ? 15 : k - 1;
            checks++; if (sbus.ops_done !== 4'(exp_cnt)) begin errors++; $display("FAIL sat_ops[%0d]: got %0d want %0d", k, sbus.ops_done, exp_cnt); end
        end
        sbus.req_valid = 4'b0000;
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        sat_reset       = 1'b1;
        sbus.req_valid  = '0;
        sbus.req_a      = '0;
        sbus.req_b      = '0;
        sbus.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_hold();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares the single 32-bit ADD unit in the MIPS datapath between several requesters, e.g. the PC+4 incrementer, the branch-target adder and the ALU add path.
- Selects one requester per transaction using round-robin arbitration.
- Presents the operands to one ADD instance and registers the sum with the requester ID.
- Holds the result until the consumer accepts it.
- Throughput: one operation in flight, back-to-back issue possible.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and sum width.
- ID_W, 2, width of requester index; must be at least clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_sum  out  WIDTH  a+b modulo 2^WIDTH.
- resp_ovf  out  1  signed overflow: sign(a)==sign(b) and sign(sum)!=sign(a).
- ops_done  out  CNT_W  count of completed responses, saturating.

Behaviour:
- Reset, synchronous, takes priority over all other activity:
  - resp_valid=0, resp_id=0, resp_sum=0, resp_ovf=0, ops_done=0.
  - Round-robin pointer rr_ptr=0, state=IDLE.
  - Reset asserted mid-transaction drops the held result with no response and no count.
- States:
  - IDLE: the result register is empty.
  - HOLD: the result register is full and resp_valid=1.
- Accept condition: accept = (state==IDLE) or (state==HOLD and resp_ready).
- Grant (combinational):
  - When accept is high and any req_valid is high, grant g is the first set req_valid bit scanning upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - req_ready = one-hot(g) while accept is high, otherwise all zero.
  - req_ready never depends on the requester's own data.
- Datapath:
  - The operands of g are multiplexed into the single ADD instance.
  - The sum is computed combinationally in the grant cycle.
  - On the clock edge the arbiter captures resp_sum, resp_ovf and resp_id=g.
- Latency: a result is visible (resp_valid=1) on the cycle after the request handshake.
- Transitions:
  - IDLE + grant -> HOLD.
  - IDLE + no request -> IDLE.
  - HOLD + resp_ready + grant -> HOLD with the new result; back-to-back, no bubble.
  - HOLD + resp_ready + no request -> IDLE.
  - HOLD + !resp_ready -> HOLD; all outputs held stable, req_ready all zero.
- Pointer: rr_ptr <= (g+1) mod NUM_REQ on each grant; unchanged otherwise.
- Fairness: a continuously asserted request is granted within NUM_REQ accepting cycles.
- ops_done: increments when resp_valid and resp_ready are both high; holds at all-ones once it reaches all-ones.
- Overflow and wrap:
  - The sum wraps modulo 2^WIDTH.
  - The carry-out is discarded.
  - resp_ovf is purely signed, for the add/addu distinction downstream.
- Requesters hold a, b and valid stable until they see req_ready. The arbiter does not check this.

Decomposition:
- Shared package: the arbiter state encoding (IDLE, HOLD) and a default DATA_WIDTH=32 constant shared with ADD.
- The round-robin priority pick (rr_ptr, req_valid -> one-hot grant and index) is natural as one sub-module, rr_pick.
- The existing ADD module is instantiated unchanged for the sum.

Test Plan:
- Reset, then a single request: req_valid=4'b0001, a=15, b=15. Next cycle: resp_valid=1, resp_id=0, resp_sum=30, resp_ovf=0. With resp_ready=1: ops_done=1, state returns to IDLE.
- All four requesters valid continuously, requester i adds i+i, resp_ready=1 every cycle. Required: grants ordered 0,1,2,3,0; one result per cycle; sums 0,2,4,6.
- Backpressure: resp_ready=0 for 3 cycles with requester 2 pending. Required: resp_sum and resp_id unchanged throughout, req_ready=0; requester 2 is granted on the cycle resp_ready rises.
- Wrap and overflow: a=32'h7FFFFFFF, b=1 gives sum 32'h80000000 with ovf=1. a=32'hFFFFFFFF, b=1 gives sum 0 with ovf=0.
- Reset in HOLD: assert reset for 1 cycle while resp_valid=1. Required: resp_valid=0, ops_done=0, rr_ptr=0 on the next cycle; next request from requester 3 returns resp_id=3.
- Saturation: with CNT_W=4, complete 20 operations. Required: ops_done stops at 15.
